keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_evt_fifo.sv | 75 +++++++
 rtl/keypad_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: FSM states and event layout.
package keypad_pkg;

    localparam int EVT_W   = 8;
    localparam int IDX_W   = 7;
    localparam int REL_BIT = 7;
    localparam int DEB_W   = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } scan_state_t;

    // Bit REL_BIT of the packed event is the release flag.
    typedef struct packed {
        logic             rel;
        logic [IDX_W-1:0] idx;
    } evt_t;

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event stream: valid/ready handshake carrying {release flag, key index}.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic             evt_valid;
    logic             evt_ready;
    logic [EVT_W-1:0] evt_code;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/keypad_evt_fifo.sv
// Purpose: small power-of-two event queue with a sticky drop flag.
// Latency: push to pop_vld 1 clk; head appears on pop_dat with no extra register stage.
// Backpressure: push when full is dropped (sets overflow) unless a pop frees the slot that cycle.
module keypad_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] last_q;
    logic             ovf_q;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign drop    = push_vld && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // When empty the output keeps showing the most recently consumed entry.
    assign pop_vld  = !empty;
    assign pop_dat  = empty ? last_q : mem[rd_ptr];
    assign overflow = ovf_q;

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: row-scanning matrix keypad decoder with press/release debounce and an event queue.
// Latency: event is pushed on the tick that completes debounce; evt_valid follows 1 clk later.
// Backpressure: evt_ready stalls the queue; events arriving to a full queue are dropped (overflow).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 312500,
    parameter int DEB_SCANS  = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_out,
    keypad_scanner_if.master  evt,
    output logic              key_held,
    output logic              overflow
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]    div_q;
    logic             tick;
    logic [COLS-1:0]  col_meta;
    logic [COLS-1:0]  col_smp;
    scan_state_t      state_q;
    scan_state_t      state_d;
    logic [RW-1:0]    row_q;
    logic [RW-1:0]    row_d;
    logic [CW-1:0]    cand_q;
    logic [CW-1:0]    cand_d;
    logic [DEB_W-1:0] deb_q;
    logic [DEB_W-1:0] deb_d;
    logic [CW-1:0]    first_zero;
    logic [RW-1:0]    next_row;
    logic             key_down;
    logic             deb_done;
    logic             push_vld;
    evt_t             push_evt;

    assign tick = (div_q == DW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // Columns come from mechanical switches; bring them into the clock domain first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= '1;
            col_smp  <= '1;
        end else begin
            col_meta <= col_in;
            col_smp  <= col_meta;
        end
    end

    always_comb begin
        first_zero = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!col_smp[c]) begin
                first_zero = CW'(c);
            end
        end
    end

    assign next_row = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    assign key_down = !col_smp[cand_q];
    assign deb_done = ((deb_q + DEB_W'(1)) == DEB_W'(DEB_SCANS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            row_q   <= '0;
            cand_q  <= '0;
            deb_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cand_q  <= cand_d;
            deb_q   <= deb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cand_d  = cand_q;
        deb_d   = deb_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (&col_smp) begin
                        row_d = next_row;
                    end else begin
                        cand_d  = first_zero;
                        deb_d   = '0;
                        state_d = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (key_down) begin
                        deb_d = deb_q + DEB_W'(1);
                        if (deb_done) begin
                            state_d = HELD;
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!key_down) begin
                        deb_d   = '0;
                        state_d = REL_DB;
                    end
                end
                REL_DB: begin
                    if (!key_down) begin
                        deb_d = deb_q + DEB_W'(1);
                        if (deb_done) begin
                            state_d = SCAN;
                            row_d   = next_row;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        row_out       = ~(ROWS'(1) << row_q);
        key_held      = (state_q == HELD) || (state_q == REL_DB);
        push_vld      = tick && deb_done &&
                        (((state_q == PRESS_DB) && key_down) ||
                         ((state_q == REL_DB) && !key_down));
        push_evt.rel  = (state_q == REL_DB);
        push_evt.idx  = IDX_W'(int'(row_q) * COLS + int'(cand_q));
    end

    keypad_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_evt),
        .pop_rdy  (evt.evt_ready),
        .pop_vld  (evt.evt_valid),
        .pop_dat  (evt.evt_code),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural switch matrix (one key at a time).
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       key_held;
    logic       overflow;
    logic       evt_ready;
    logic       key_on;
    int         key_row;
    int         key_col;
    int         tests = 0;
    int         fails = 0;

    keypad_scanner_if evt_if ();
    assign evt_if.evt_ready = evt_ready;

    always #5 clk = ~clk;

    // A pressed key pulls its column low only while its row is driven.
    assign col_in = (key_on && row_out[key_row] == 1'b0) ? ~(4'b0001 << key_col) : 4'b1111;

    keypad_scanner #(
        .ROWS       (4),
        .COLS       (4),
        .SCAN_DIV   (4),
        .DEB_SCANS  (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .col_in   (col_in),
        .row_out  (row_out),
        .evt      (evt_if.master),
        .key_held (key_held),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && evt_if.evt_valid !== 1'b1; i++) cyc(1);
        check({tag, "_valid"}, {7'b0, evt_if.evt_valid}, 8'h01);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp, input int budget);
        wait_valid(tag, budget);
        check(tag, evt_if.evt_code, exp);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
    endtask

    task automatic wait_held(input string tag, input logic val, input int budget);
        for (int i = 0; i < budget && key_held !== val; i++) cyc(1);
        check(tag, {7'b0, key_held}, {7'b0, val});
    endtask

    task automatic wait_row(input string tag, input logic [3:0] val, input int budget);
        for (int i = 0; i < budget && row_out !== val; i++) cyc(1);
        check(tag, {4'b0, row_out}, {4'b0, val});
    endtask

    initial begin
        rst       = 1'b0;
        evt_ready = 1'b0;
        key_on    = 1'b0;
        key_row   = 0;
        key_col   = 0;
        #2;
        check("rst_row_out",  {4'b0, row_out}, 8'h0E);
        check("rst_valid",    {7'b0, evt_if.evt_valid}, 8'h00);
        check("rst_code",     evt_if.evt_code, 8'h00);
        check("rst_held",     {7'b0, key_held}, 8'h00);
        check("rst_overflow", {7'b0, overflow}, 8'h00);

        // Idle scan: first step exactly SCAN_DIV edges after reset release.
        cyc(1);
        rst = 1'b1;
        cyc(3);
        check("idle_row0_hold", {4'b0, row_out}, 8'h0E);
        cyc(1);
        check("idle_row1", {4'b0, row_out}, 8'h0D);
        cyc(4);
        check("idle_row2", {4'b0, row_out}, 8'h0B);
        cyc(4);
        check("idle_row3", {4'b0, row_out}, 8'h07);
        cyc(4);
        check("idle_wrap", {4'b0, row_out}, 8'h0E);
        check("idle_valid", {7'b0, evt_if.evt_valid}, 8'h00);

        // Clean press of row 2, col 1 -> index 9.
        key_row = 2;
        key_col = 1;
        key_on  = 1'b1;
        pop_expect("press_2_1", 8'h09, 100);
        check("press_held", {7'b0, key_held}, 8'h01);
        check("press_row_frozen", {4'b0, row_out}, 8'h0B);
        cyc(40);
        check("hold_held", {7'b0, key_held}, 8'h01);
        check("hold_row_frozen", {4'b0, row_out}, 8'h0B);
        check("hold_no_event", {7'b0, evt_if.evt_valid}, 8'h00);
        key_on = 1'b0;
        cyc(6);
        check("reldb_held", {7'b0, key_held}, 8'h01);
        check("reldb_row_frozen", {4'b0, row_out}, 8'h0B);
        pop_expect("release_2_1", 8'h89, 60);
        check("release_flag_bit", {7'b0, evt_if.evt_code[REL_BIT]}, 8'h01);
        check("release_held_clear", {7'b0, key_held}, 8'h00);
        check("release_row_adv", {4'b0, row_out}, 8'h07);
        check("release_drained", {7'b0, evt_if.evt_valid}, 8'h00);

        // Bounce: key on row 1 seen for the detect tick plus one debounce tick.
        wait_row("bounce_sync", 4'b1101, 40);
        key_row = 1;
        key_col = 2;
        key_on  = 1'b1;
        cyc(8);
        key_on = 1'b0;
        check("bounce_row_frozen", {4'b0, row_out}, 8'h0D);
        check("bounce_not_held", {7'b0, key_held}, 8'h00);
        cyc(4);
        check("bounce_abort_no_adv", {4'b0, row_out}, 8'h0D);
        cyc(4);
        check("bounce_resume", {4'b0, row_out}, 8'h0B);
        cyc(20);
        check("bounce_no_event", {7'b0, evt_if.evt_valid}, 8'h00);

        // Overflow: six events on key 0 with the consumer stalled.
        key_row = 0;
        key_col = 0;
        for (int i = 0; i < 3; i++) begin
            key_on = 1'b1;
            wait_held("ovf_press", 1'b1, 100);
            key_on = 1'b0;
            wait_held("ovf_release", 1'b0, 60);
            if (i == 1) begin
                check("full_no_overflow", {7'b0, overflow}, 8'h00);
                check("full_valid", {7'b0, evt_if.evt_valid}, 8'h01);
            end
        end
        cyc(2);
        check("overflow_set", {7'b0, overflow}, 8'h01);
        pop_expect("drain0", 8'h00, 4);
        pop_expect("drain1", 8'h80, 4);
        pop_expect("drain2", 8'h00, 4);
        pop_expect("drain3", 8'h80, 4);
        check("drain_empty", {7'b0, evt_if.evt_valid}, 8'h00);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        check("pop_empty_code_hold", evt_if.evt_code, 8'h80);
        check("pop_empty_valid", {7'b0, evt_if.evt_valid}, 8'h00);
        check("overflow_sticky", {7'b0, overflow}, 8'h01);

        // Reset while a key on row 3, col 2 is held.
        key_row = 3;
        key_col = 2;
        key_on  = 1'b1;
        wait_held("rsth_press", 1'b1, 100);
        check("rsth_queued", {7'b0, evt_if.evt_valid}, 8'h01);
        check("rsth_code", evt_if.evt_code, 8'h0E);
        cyc(5);
        rst = 1'b0;
        #1;
        check("rsth_row_out", {4'b0, row_out}, 8'h0E);
        check("rsth_valid", {7'b0, evt_if.evt_valid}, 8'h00);
        check("rsth_code_clr", evt_if.evt_code, 8'h00);
        check("rsth_held", {7'b0, key_held}, 8'h00);
        check("rsth_overflow", {7'b0, overflow}, 8'h00);
        key_on = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(3);
        check("rsth_first_tick_hold", {4'b0, row_out}, 8'h0E);
        cyc(1);
        check("rsth_first_tick", {4'b0, row_out}, 8'h0D);
        cyc(60);
        check("rsth_no_release", {7'b0, evt_if.evt_valid}, 8'h00);
        check("rsth_idle_held", {7'b0, key_held}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
